// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the event sources, the uart_tx serializer and the arbiter.
// The arbiter uses the master view; the environment around it uses the slave view.
interface uart_tx_arbiter_if;
    logic [3:0]  req;
    logic [11:0] req_data;
    logic        tx_active;
    logic        tx_done;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic [3:0]  pending;
    logic [3:0]  overrun;
    logic        timeout;
    logic        busy;

    modport master (
        input  req, req_data, tx_active, tx_done,
        output tx_dv, tx_byte, pending, overrun, timeout, busy
    );

    modport slave (
        output req, req_data, tx_active, tx_done,
        input  tx_dv, tx_byte, pending, overrun, timeout, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx serializer among four strobed event sources.
// Each rising strobe queues one frame {3'b001, id, code}; frames launch one at a time.
module uart_tx_arbiter #(
    parameter int TIMEOUT = 65536,
    parameter int TW      = 17
) (
    input logic               clk,
    input logic               rst,
    uart_tx_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    state_t          state_r;
    logic [3:0]      last_req_r;
    logic [3:0]      pending_r;
    logic [3:0]      overrun_r;
    logic [3:0][2:0] payload_r;
    logic [1:0]      last_grant_r;
    logic [TW-1:0]   cnt_r;
    logic            tx_dv_r;
    logic [7:0]      tx_byte_r;
    logic            timeout_r;
    logic            busy_r;

    logic [3:0] edge_s;
    logic [3:0] clr_s;
    logic [1:0] winner_s;
    logic [1:0] idx_s;
    logic       found_s;
    logic       launch_s;

    assign edge_s = bus.req & ~last_req_r;

    // Round-robin search beginning just after the previous grant; first pending source wins.
    always_comb begin
        winner_s = last_grant_r;
        found_s  = 1'b0;
        idx_s    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx_s    = last_grant_r + 2'(k);
            winner_s = (!found_s && pending_r[idx_s]) ? idx_s : winner_s;
            found_s  = found_s | pending_r[idx_s];
        end
    end

    assign launch_s = (state_r == IDLE) && found_s && !bus.tx_active;
    assign clr_s    = launch_s ? (4'b0001 << winner_s) : 4'b0000;

    // Edge capture: a new edge on the source being launched re-queues it without an overrun.
    always_ff @(posedge clk) begin
        last_req_r <= bus.req;
        if (rst) begin
            pending_r <= 4'b0000;
            overrun_r <= 4'b0000;
            payload_r <= '0;
        end else begin
            pending_r <= (pending_r & ~clr_s) | edge_s;
            overrun_r <= overrun_r | (edge_s & pending_r & ~clr_s);
            for (int i = 0; i < 4; i++) begin
                if (edge_s[i]) begin
                    payload_r[i] <= bus.req_data[3*i +: 3];
                end
            end
        end
    end

    // Launch FSM with registered strobe, byte, busy and sticky timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= 2'd3;
            cnt_r        <= '0;
            tx_dv_r      <= 1'b0;
            tx_byte_r    <= 8'h00;
            timeout_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (launch_s) begin
                        tx_byte_r    <= {3'b001, winner_s, payload_r[winner_s]};
                        last_grant_r <= winner_s;
                        tx_dv_r      <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= LAUNCH;
                    end else begin
                        tx_dv_r      <= 1'b0;
                    end
                end
                LAUNCH: begin
                    tx_dv_r <= 1'b0;
                    cnt_r   <= '0;
                    state_r <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    cnt_r <= cnt_r + TW'(1);
                    if (bus.tx_done) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        // Frame abandoned; it is not retried.
                        timeout_r <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    tx_dv_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_dv   = tx_dv_r;
    assign bus.tx_byte = tx_byte_r;
    assign bus.pending = pending_r;
    assign bus.overrun = overrun_r;
    assign bus.timeout = timeout_r;
    assign bus.busy    = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: capture table, directed corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_uart_tx_arbiter;

    localparam int FRAME = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_tx_arbiter_if bus ();

    logic stub_active = 1'b0, stub_done = 1'b0, hold_active = 1'b0, inj_done = 1'b0;
    logic done_en = 1'b1;
    int   stub_cnt = 0;

    assign bus.tx_active = stub_active | hold_active;
    assign bus.tx_done   = stub_done | inj_done;

    uart_tx_arbiter #(.TIMEOUT(100), .TW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] data;
        logic [3:0]  exp_pend;
        logic [3:0]  exp_ovr;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst = 1'b1;
        bus.req = r;
        bus.req_data = 12'h000;
        inj_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic wait_dv(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (bus.tx_dv) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Round-robin choice from the rule: scan last+1, last+2, last+3, last+0.
    function automatic logic [1:0] rr_pick(input logic [3:0] p, input logic [1:0] last);
        int j;
        rr_pick = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            j = (int'(last) + k) % 4;
            if (p[j]) rr_pick = 2'(j);
        end
    endfunction

    // Behavioural uart_tx stand-in: busy for FRAME cycles after a launch, then a done pulse.
    initial begin
        forever begin
            @(negedge clk);
            stub_done = 1'b0;
            if (rst) begin
                stub_active = 1'b0;
                stub_cnt = 0;
            end else if (stub_active) begin
                if (stub_cnt == 0) begin
                    stub_active = 1'b0;
                    stub_done = done_en;
                end else begin
                    stub_cnt--;
                end
            end else if (bus.tx_dv) begin
                stub_active = 1'b1;
                stub_cnt = FRAME;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    bit          ok;
    int          nf, ndv, done_iter, launch_iter;
    bit          saw_done, last_dv;
    logic [7:0]  expb[4];
    logic [1:0]  grants[4];
    logic [3:0]  rs, m_pend, m_ovr, e_nxt, prev_req, new_req, clr;
    logic [11:0] d_nxt;
    logic [2:0]  m_pay[4];
    logic [1:0]  m_last, w;
    logic [7:0]  b3;

    initial begin
        bus.req = 4'h0;
        bus.req_data = 12'h000;

        // ---- reset values, capture table (launch blocked by tx_active) ----
        hold_active = 1'b1;
        do_reset(4'hF);
        chk("rst_tx_dv", bus.tx_dv, 1'b0);
        chk("rst_tx_byte", bus.tx_byte, 8'h00);
        chk("rst_pending", bus.pending, 4'h0);
        chk("rst_overrun", bus.overrun, 4'h0);
        chk("rst_timeout", bus.timeout, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);

        tbl[0] = '{4'hF, 12'h000, 4'h0, 4'h0};
        tbl[1] = '{4'h0, 12'h000, 4'h0, 4'h0};
        tbl[2] = '{4'h1, 12'h005, 4'h1, 4'h0};
        tbl[3] = '{4'h0, 12'h000, 4'h1, 4'h0};
        tbl[4] = '{4'h1, 12'h006, 4'h1, 4'h1};
        tbl[5] = '{4'h6, 12'h028, 4'h7, 4'h1};
        tbl[6] = '{4'h6, 12'h000, 4'h7, 4'h1};
        tbl[7] = '{4'h8, 12'hE00, 4'hF, 4'h1};
        tbl[8] = '{4'hE, 12'h1D0, 4'hF, 4'h7};
        for (int i = 0; i < 9; i++) begin
            bus.req = tbl[i].req;
            bus.req_data = tbl[i].data;
            tick();
            chk($sformatf("tbl%0d_pending", i), bus.pending, tbl[i].exp_pend);
            chk($sformatf("tbl%0d_overrun", i), bus.overrun, tbl[i].exp_ovr);
            chk($sformatf("tbl%0d_no_dv", i), bus.tx_dv, 1'b0);
        end
        hold_active = 1'b0;
        tick();
        chk("tbl_release_dv", bus.tx_dv, 1'b1);
        chk("tbl_release_byte", bus.tx_byte, 8'h26);

        // ---- single request after reset ----
        do_reset(4'h0);
        bus.req_data = 12'h140;
        bus.req = 4'b0100;
        tick();
        chk("single_pend_t1", bus.pending, 4'b0100);
        chk("single_dv_t1", bus.tx_dv, 1'b0);
        tick();
        chk("single_dv_t2", bus.tx_dv, 1'b1);
        chk("single_byte", bus.tx_byte, 8'h35);
        chk("single_busy", bus.busy, 1'b1);
        chk("single_pend_t2", bus.pending, 4'b0000);
        ndv = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.tx_dv) ndv++;
        end
        chk("single_extra_dv", ndv, 0);
        chk("single_busy_end", bus.busy, 1'b0);

        // ---- all four strobe together ----
        do_reset(4'h0);
        expb[0] = 8'h21; expb[1] = 8'h2A; expb[2] = 8'h33; expb[3] = 8'h3C;
        bus.req_data = {3'd4, 3'd3, 3'd2, 3'd1};
        bus.req = 4'hF;
        nf = 0; saw_done = 1'b0; done_iter = 0; last_dv = 1'b0;
        for (int n = 0; n < 400 && nf < 4; n++) begin
            tick();
            if (bus.tx_done) begin
                saw_done = 1'b1;
                done_iter = n;
            end
            if (bus.tx_dv) begin
                chk($sformatf("all_byte%0d", nf), bus.tx_byte, expb[nf]);
                chk("all_single_pulse", last_dv, 1'b0);
                if (nf > 0) begin
                    chk("all_after_done", saw_done, 1'b1);
                    // done seen at iteration d+1 -> launch visible at d+2
                    chk("all_gap", n - done_iter, 1);
                end
                saw_done = 1'b0;
                nf++;
            end
            last_dv = bus.tx_dv;
        end
        chk("all_frames", nf, 4);

        // ---- fairness: 0 and 1 re-strobe after each of their launches ----
        do_reset(4'h0);
        bus.req = 4'b0011;
        nf = 0; rs = 4'h0;
        for (int n = 0; n < 300 && nf < 4; n++) begin
            tick();
            if (bus.tx_dv) begin
                grants[nf] = bus.tx_byte[4:3];
                nf++;
                rs = 4'b0001 << bus.tx_byte[4:3];
                bus.req = bus.req & ~rs;
            end else if (rs != 4'h0) begin
                bus.req = bus.req | rs;
                rs = 4'h0;
            end
        end
        chk("fair_frames", nf, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("fair_grant%0d", i), grants[i], 2'(i % 2));

        // ---- overrun on source 3 while source 0 is in flight ----
        do_reset(4'h0);
        bus.req = 4'b0001;
        wait_dv(5, ok);
        chk("ovr_launch0", ok, 1'b1);
        chk("ovr_byte0", bus.tx_byte, 8'h20);
        bus.req = 4'b1001; bus.req_data = 12'(2) << 9;
        tick();
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b1001; bus.req_data = 12'(6) << 9;
        tick();
        tick();
        chk("ovr_flag", bus.overrun, 4'b1000);
        chk("ovr_pend", bus.pending, 4'b1000);
        ndv = 0; b3 = 8'h00;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.tx_dv) begin
                ndv++;
                b3 = bus.tx_byte;
            end
        end
        chk("ovr_one_frame", ndv, 1);
        chk("ovr_byte3", b3, 8'h3E);

        // ---- reset boundary ----
        rst = 1'b1;
        bus.req = 4'hF;
        repeat (3) tick();
        rst = 1'b0;
        ndv = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.tx_dv) ndv++;
        end
        chk("rstF_no_dv", ndv, 0);
        chk("rstF_pending", bus.pending, 4'h0);
        bus.req = 4'h0;
        tick();
        bus.req = 4'b0111;
        wait_dv(5, ok);
        chk("midrst_launch", ok, 1'b1);
        repeat (5) tick();
        chk("midrst_busy", bus.busy, 1'b1);
        chk("midrst_pend", bus.pending, 4'b0110);
        rst = 1'b1;
        repeat (2) tick();
        chk("midrst_tx_dv", bus.tx_dv, 1'b0);
        chk("midrst_tx_byte", bus.tx_byte, 8'h00);
        chk("midrst_pending", bus.pending, 4'h0);
        chk("midrst_overrun", bus.overrun, 4'h0);
        chk("midrst_timeout", bus.timeout, 1'b0);
        chk("midrst_busy0", bus.busy, 1'b0);
        rst = 1'b0;
        ndv = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.tx_dv) ndv++;
        end
        chk("midrst_no_dv", ndv, 0);

        // ---- timeout, with a stray done during LAUNCH ----
        done_en = 1'b0;
        do_reset(4'h0);
        bus.req_data = (12'(5) << 6) | (12'(3) << 3);
        bus.req = 4'b0110;
        wait_dv(5, ok);
        chk("to_launch", ok, 1'b1);
        chk("to_byte1", bus.tx_byte, 8'h2B);
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        chk("to_stray_done_ignored", bus.busy, 1'b1);
        repeat (99) tick();
        chk("to_not_yet", bus.timeout, 1'b0);
        tick();
        chk("to_set", bus.timeout, 1'b1);
        chk("to_busy_clear", bus.busy, 1'b0);
        done_en = 1'b1;
        tick();
        chk("to_next_dv", bus.tx_dv, 1'b1);
        chk("to_next_byte", bus.tx_byte, 8'h35);
        repeat (30) tick();
        chk("to_sticky", bus.timeout, 1'b1);

        // ---- randomized run against the reference model ----
        do_reset(4'h0);
        m_pend = 4'h0; m_ovr = 4'h0; m_last = 2'd3; prev_req = 4'h0;
        for (int i = 0; i < 4; i++) m_pay[i] = 3'd0;
        last_dv = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            new_req = prev_req;
            if (n < 1300) begin
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(7) == 0) new_req[b] = ~new_req[b];
            end
            d_nxt = 12'($urandom);
            bus.req = new_req;
            bus.req_data = d_nxt;
            e_nxt = new_req & ~prev_req;
            prev_req = new_req;
            tick();
            clr = 4'h0;
            if (bus.tx_dv) begin
                chk("rnd_launch_has_pending", (m_pend != 4'h0), 1'b1);
                chk("rnd_single_pulse", last_dv, 1'b0);
                w = rr_pick(m_pend, m_last);
                chk("rnd_byte", bus.tx_byte, {3'b001, w, m_pay[w]});
                m_last = w;
                clr = 4'b0001 << w;
            end
            m_ovr = m_ovr | (e_nxt & m_pend & ~clr);
            m_pend = (m_pend & ~clr) | e_nxt;
            for (int i = 0; i < 4; i++)
                if (e_nxt[i]) m_pay[i] = d_nxt[3*i +: 3];
            chk("rnd_pending", bus.pending, m_pend);
            chk("rnd_overrun", bus.overrun, m_ovr);
            last_dv = bus.tx_dv;
        end
        chk("rnd_drained", bus.pending, 4'h0);
        chk("rnd_no_timeout", bus.timeout, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single 9600-baud `uart_tx` serializer (50 MHz clock, CLKS_PER_BIT 5209) among four event sources, so that several front-panel and sensor strobes can report over the one Arduino link. Each source raises a strobe together with a 3-bit code. The block captures every strobe on its rising edge and queues one pending frame per source. It then grants the transmitter in round-robin order, launching one frame at a time with a single-cycle `tx_dv` pulse, and waits for `tx_done` before granting the next source. It sits between the event sources and `uart_tx`, driving that module's `i_Tx_DV` and `i_Tx_Byte` and monitoring its `o_Tx_Active` and `o_Tx_Done`.

## Interface
- `TIMEOUT`, default 65536: cycles allowed in WAIT_DONE before the frame is abandoned. This is more than one 10-bit frame of 52090 cycles.
- `TW`, default 17: width of the timeout counter. Must satisfy `TIMEOUT` ≤ 2^TW.
- `clk`  in  1: system clock, 50 MHz. One clock domain only.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  4: per-source strobe levels. A rising edge means "send".
- `req_data`  in  12: payload codes. Bits [3i+2:3i] belong to source i. Sampled on the cycle the edge is detected.
- `tx_active`  in  1: from `uart_tx` `o_Tx_Active`.
- `tx_done`  in  1: from `uart_tx` `o_Tx_Done`, a one-cycle pulse.
- `tx_dv`  out  1: to `i_Tx_DV`. One-cycle launch pulse.
- `tx_byte`  out  8: to `i_Tx_Byte`.
- `pending`  out  4: per-source frame-queued flags.
- `overrun`  out  4: sticky flags. Set when a source strobes while its frame is still pending.
- `timeout`  out  1: sticky flag. Set when a launched frame never reports `tx_done`.
- `busy`  out  1: high in LAUNCH and WAIT_DONE.

## Operation
- **Edge detection**
  - The last-sample register `last_req` loads the current `req` value during reset, so a source held high through reset produces no edge.
  - An edge on source i occurs when `req[i] & ~last_req[i]`.
- **Capture on edge i**
  - `pending[i]` is set to 1.
  - `payload[i]` is loaded from `req_data[3i+2:3i]`.
  - If `pending[i]` was already 1 and is not being cleared that cycle, `overrun[i]` is set to 1 and the newer payload replaces the older one.
  - If the edge coincides with the launch of source i, the new edge wins: `pending[i]` stays 1 and no overrun is flagged.
- **Frame format:** `tx_byte = {3'b001, id[1:0], payload[id]}`.
- **Round-robin arbitration**
  - Register `last_grant` (2 bits) resets to 3.
  - Search order is `last_grant+1`, `+2`, `+3`, `+0`, all modulo 4.
  - The first source found with `pending=1` wins.
  - After reset the priority order is therefore 0, 1, 2, 3.
- **FSM states and transitions**
  - **IDLE:** if any `pending` bit is set and `tx_active=0`, do the following and go to LAUNCH:
    - register `tx_byte` for the winner;
    - set `last_grant` to the winner;
    - clear the winner's `pending` bit;
    - set `tx_dv` to 1.
  - **LAUNCH:** `tx_dv` is high for exactly this one cycle. Clear the timeout counter. Go to WAIT_DONE.
  - **WAIT_DONE:**
    - `tx_dv` is 0 and the counter increments every cycle.
    - If `tx_done` is 1, go to IDLE.
    - Otherwise, if the counter reaches `TIMEOUT-1`, set `timeout` and go to IDLE; the frame is lost and is not retried.
- `tx_byte` holds its last value between frames.
- **Reset values**
  - `tx_dv=0`, `tx_byte=8'h00`, `pending=0`, `overrun=0`, `timeout=0`, `busy=0`.
  - State is IDLE and `last_grant=3`.
  - Reset mid-frame abandons the frame and clears all queued requests. The downstream `uart_tx` is reset by the same `rst`.
- A `tx_done` pulse that arrives while the FSM is in IDLE or LAUNCH is ignored.

## Timing
- Edge sampled at cycle t → `pending[i]=1` at t+1 → `tx_dv=1` and `tx_byte` valid at t+2 (FSM idle, `tx_active=0`) → `busy=1` from t+2.
- The `tx_dv`/`tx_byte` launch registers and the `pending` bit clear update on the same clock edge.
- `tx_done` pulse at cycle d → IDLE at d+1 → next `tx_dv` at d+2 at the earliest.
- Transmission is back-to-back. With all four sources pending, four frames go out in order 0, 1, 2, 3. The gap between frames is 2 cycles plus the `uart_tx` overhead.
- Flag updates (`pending`, `overrun`, `timeout`) appear one cycle after the causing event.

## Test plan
- **Single request after reset:** `req[2]` rises with `req_data[8:6]=3'b101`; `uart_tx` is attached.
  - `tx_dv` pulses once 2 cycles later with `tx_byte=8'h35`.
  - The serial line carries 0x35 at 9600 baud.
  - `pending` returns to `4'b0000`.
- **All sources strobe in the same cycle** with codes 1, 2, 3, 4:
  - Frames go out in order `8'h21`, `8'h2A`, `8'h33`, `8'h3C`.
  - Exactly one `tx_dv` per frame, each issued after the previous `tx_done`.
- **Fairness:** source 0 re-strobes immediately after each of its launches while source 1 is also pending.
  - Grants alternate 0, 1, 0, 1.
  - Source 1 is never starved.
- **Overrun:** source 3 strobes twice, with codes 2 then 6, while the frame from source 0 is in flight.
  - `overrun[3]=1`.
  - Only one frame is sent for source 3, `tx_byte=8'h3E`.
- **Reset boundary:** hold `req=4'hF` through `rst`, then release reset.
  - No frame is sent.
  - Assert `rst` in the middle of WAIT_DONE with two sources pending: all outputs return to their reset values and no later `tx_dv` appears.
- **Timeout:** tie `tx_done` to 0 with `TIMEOUT=100`, then strobe source 1.
  - `timeout` sets 100 cycles after LAUNCH.
  - The FSM returns to IDLE and services the next pending source.
